// File: rtl/d_pipe_pkg.sv
// Shared definitions for the d_pipe register-slice family.
package d_pipe_pkg;

    localparam int MAX_STAGES = 16;

    // Ceiling log2 that never returns 0, so a counter width is always legal.
    function automatic int clog2_safe(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One pipeline stage: a valid bit plus a payload register that only loads real data.
module d_pipe_stage
    import d_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             adv,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            if (flush) begin
                valid <= 1'b0;
            end else if (adv) begin
                valid <= prev_valid;
            end
            // Payload toggles only when a real item moves in; bubbles leave it idle.
            if (adv && prev_valid && !flush) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/d_pipe_reg.sv
// Multi-stage valid/ready register slice with bubble collapsing and synchronous flush.
// Optional occupancy output enabled by defining D_PIPE_REG_OCC_EN.
module d_pipe_reg
    import d_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef D_PIPE_REG_OCC_EN
    ,
    output logic [clog2_safe(STAGES+1)-1:0] occ
`endif
);

    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
        $error("d_pipe_reg: STAGES out of range");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] stage_in_v;
    logic [WIDTH-1:0]  d          [STAGES];
    logic [WIDTH-1:0]  stage_in_d [STAGES];

    // Handshake: an item moves at input when in_valid & in_ready and at output when
    // out_valid & out_ready; in_ready never depends on in_valid, and out_* are registers.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain  = !v[i] || chain;
            adv[i] = chain;
        end
    end

    assign in_ready = rst_n && adv[0] && !flush;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_in_v[i] = in_valid && in_ready;
            assign stage_in_d[i] = in_data;
        end else begin : g_body
            assign stage_in_v[i] = v[i-1];
            assign stage_in_d[i] = d[i-1];
        end

        d_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush      (flush),
            .adv        (adv[i]),
            .prev_valid (stage_in_v[i]),
            .prev_data  (stage_in_d[i]),
            .valid      (v[i]),
            .data       (d[i])
        );
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

`ifdef D_PIPE_REG_OCC_EN
    localparam int OCC_W = clog2_safe(STAGES + 1);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Tracked from transfers rather than a popcount of v; flush wins over any exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            occ <= occ + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end
`endif

endmodule

// File: tb/tb_d_pipe_reg.sv
// Scoreboard bench for d_pipe_reg: directed handshake scenarios plus random traffic.
module tb_d_pipe_reg;
    import d_pipe_pkg::*;

    localparam int               WIDTH     = 8;
    localparam int               STAGES    = 2;
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h3C;
    localparam int               OCC_W     = clog2_safe(STAGES + 1);

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
`ifdef D_PIPE_REG_OCC_EN
    logic [OCC_W-1:0] occ;
`endif

    d_pipe_reg #(
        .WIDTH     (WIDTH),
        .STAGES    (STAGES),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef D_PIPE_REG_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    // Scoreboard: payloads in acceptance order and the cycle each was accepted.
    logic [WIDTH-1:0] exp_q[$];
    int               acc_q[$];
    logic             exp_rdy;
    logic             exp_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input side of the model: the pipeline refuses only when every stage is full and
    // downstream is stalled (bubbles always collapse), or during flush.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("in_ready_in_reset", in_ready, 0);
        end else begin
            exp_rdy = !flush && (exp_q.size() < STAGES || out_ready);
            check("in_ready", in_ready, exp_rdy);
`ifdef D_PIPE_REG_OCC_EN
            check("occ", occ, exp_q.size());
`endif
            if (in_valid && exp_rdy) begin
                exp_q.push_back(in_data);
                acc_q.push_back(cyc);
            end
        end
    end

    // Monitor: the oldest item is presented once STAGES cycles have passed since acceptance.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            check("out_valid_in_reset", out_valid, 0);
            check("out_data_in_reset", out_data, RESET_VAL);
        end else begin
            exp_v = (exp_q.size() > 0) && (cyc - acc_q[0] >= STAGES);
            check("out_valid", out_valid, exp_v);
            if (exp_v && out_ready) begin
                check("out_data", out_data, exp_q[0]);
                void'(exp_q.pop_front());
                void'(acc_q.pop_front());
            end
            if (flush) begin
                exp_q.delete();
                acc_q.delete();
            end
        end
    end

    // Driver: apply one cycle of inputs (called at posedge+1) and report acceptance.
    task automatic cycle_drive(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                               input logic fl, output logic acc);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        #2;
        acc = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) begin
            cycle_drive(1'b0, '0, 1'b1, 1'b0, acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic             acc;
        logic             pend;
        logic [WIDTH-1:0] pd;

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, RESET_VAL);
        check("reset_in_ready", in_ready, 0);
        rst_n = 1'b1;

        // Single item latency
        cycle_drive(1'b1, 8'hA5, 1'b1, 1'b0, acc);
        check("a5_accept", acc, 1);
        check("a5_lat1_valid", out_valid, 0);
        cycle_drive(1'b0, '0, 1'b1, 1'b0, acc);
        check("a5_lat2_valid", out_valid, 1);
        check("a5_lat2_data", out_data, 8'hA5);
        idle(3);

        // Streaming at full rate
        for (int k = 1; k <= 16; k++) begin
            cycle_drive(1'b1, WIDTH'(k), 1'b1, 1'b0, acc);
            check("stream_accept", acc, 1);
        end
        idle(4);

        // Backpressure: two fit, third waits until the first leaves
        for (int k = 0; k < 3; k++) begin
            cycle_drive(1'b1, 8'h50 + WIDTH'(k), 1'b0, 1'b0, acc);
            check("bp_accept", acc, (k < 2) ? 1 : 0);
        end
        cycle_drive(1'b1, 8'h52, 1'b1, 1'b0, acc);
        check("bp_release_accept", acc, 1);
        idle(4);

        // Bubble collapse under stall
        cycle_drive(1'b1, 8'h11, 1'b0, 1'b0, acc);
        cycle_drive(1'b0, '0, 1'b0, 1'b0, acc);
        cycle_drive(1'b1, 8'h22, 1'b0, 1'b0, acc);
        check("bubble_second_accept", acc, 1);
        check("bubble_full_in_ready", in_ready, 0);
        check("bubble_out_valid", out_valid, 1);
        check("bubble_out_data", out_data, 8'h11);
        idle(4);

        // Flush while full with a new item offered
        cycle_drive(1'b1, 8'h61, 1'b0, 1'b0, acc);
        cycle_drive(1'b1, 8'h62, 1'b0, 1'b0, acc);
        cycle_drive(1'b1, 8'h77, 1'b0, 1'b1, acc);
        check("flush_not_accepted", acc, 0);
        check("flush_out_valid", out_valid, 0);
`ifdef D_PIPE_REG_OCC_EN
        check("flush_occ", occ, 0);
`endif
        idle(2);

        // Random traffic with occasional flush; payload held until accepted
        pend = 1'b0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pd   = WIDTH'($urandom_range(0, 255));
            end
            cycle_drive(pend, pd, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < 20 && pend; i++) begin
            cycle_drive(1'b1, pd, 1'b1, 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        check("random_pending_drained", pend, 0);

        // Asynchronous reset mid-stream, between edges
        cycle_drive(1'b1, 8'h41, 1'b0, 1'b0, acc);
        cycle_drive(1'b1, 8'h42, 1'b0, 1'b0, acc);
        cycle_drive(1'b1, 8'h43, 1'b0, 1'b0, acc);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_out_data", out_data, RESET_VAL);
        check("async_rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cycle_drive(1'b1, 8'h30 + WIDTH'(k), 1'b1, 1'b0, acc);
            check("restart_accept", acc, 1);
        end
        idle(2 * STAGES + 2);
        check("drain_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/d_pipe_reg.md
Name: d_pipe_reg

Overview:
- Parametrised multi-stage register pipeline with per-stage valid bits and a valid/ready handshake.
- Successor to the single-bit D flop; generalises data width and stage depth, and adds enable-by-handshake, bubble collapsing, backpressure and synchronous flush.
- Used as a timing-closure register slice between datapath blocks.

Parameters:
- WIDTH, 8, payload width in bits (>=1)
- STAGES, 2, number of register stages (1..16)
- RESET_VAL, '0, WIDTH-bit value loaded into every data register on reset

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream data valid
- in_data  input  WIDTH  upstream payload
- in_ready  output  1  block can accept in_data this cycle
- out_valid  output  1  last stage holds valid data
- out_data  output  WIDTH  last-stage payload
- out_ready  input  1  downstream accepts this cycle

Behaviour:
- Reset: clk and rst_n; rst_n is asynchronous, active-low. While rst_n=0:
  - all stage valid bits = 0 and all data registers = RESET_VAL;
  - out_valid=0, out_data=RESET_VAL;
  - in_ready=0 during reset. After rst_n deasserts, in_ready follows the rules below from the first edge.
- Stage i holds v[i] and d[i]; stage STAGES-1 drives out_valid/out_data directly (registered outputs, no comb path from in_data).
- Advance condition: adv[STAGES-1] = !v[STAGES-1] | out_ready; adv[i] = !v[i] | adv[i+1] (bubble collapsing). The ready chain is combinational.
- in_ready = adv[0] & !flush.
- On each edge, for every stage with adv[i]=1:
  - v[i] <= v[i-1] and d[i] <= d[i-1];
  - stage 0 takes in_valid & in_ready and in_data;
  - d[i] updates only when the incoming valid=1; data holds otherwise (power).
- Stages with adv[i]=0 hold.
- Transfers: a transfer occurs at input when in_valid & in_ready, and at output when out_valid & out_ready.
- Latency and throughput: STAGES cycles from input transfer to out_valid when unstalled; 1 item per cycle sustained.
- Full: all v=1 and out_ready=0 -> in_ready=0. out_ready=1 with all v=1 -> in_ready=1, with simultaneous in/out transfer.
- Empty: out_valid=0. A bubble between items collapses when downstream stalls.
- Flush=1: at the edge, all v <= 0; data unchanged.
  - An in_valid in the same cycle is not accepted (in_ready=0).
  - An out transfer in the flush cycle still counts if out_valid&out_ready.
- Ordering: strict FIFO, no duplication or loss except by flush.
- Protocol: upstream must hold in_data stable while in_valid&!in_ready. out_valid never drops without an out transfer or flush.

Optional Feature:
- Macro D_PIPE_REG_OCC_EN.
- Defined:
  - adds output port occ, width $clog2(STAGES+1), equal to the count of set valid bits;
  - registered, updated every edge; reset 0, flush -> 0.
- Undefined: port absent, no counter logic.

Decomposition:
- Shared package d_pipe_pkg:
  - function clog2_safe, returning >=1;
  - localparam MAX_STAGES=16.
- One natural sub-module, d_pipe_stage: one valid+data register with adv/flush/reset. d_pipe_reg instantiates STAGES copies via generate.

Test Plan:
- Reset, then in_valid=1 with data 0xA5 and out_ready=1, STAGES=2 -> out_valid=1, out_data=0xA5 exactly 2 cycles after acceptance; out_data=RESET_VAL during reset.
- Streaming: 0x01..0x10 on consecutive cycles with out_ready=1 -> same sequence out, one per cycle, in_ready constantly 1.
- Backpressure: out_ready=0 while 3 items offered, STAGES=2 -> 2 accepted, in_ready=0 on 3rd; out_ready=1 -> 3rd accepted same cycle first item leaves; order preserved.
- Bubble collapse: item 0x11, idle cycle, item 0x22, with out_ready=0 -> both held in stages, v=11, in_ready=0.
- Flush with pipeline full and in_valid=1 -> next cycle out_valid=0, input not accepted. With D_PIPE_REG_OCC_EN, occ=0.
- Async reset mid-stream: rst_n low between edges -> out_valid=0 immediately, not at the next edge; after release, the stream restarts cleanly.
